// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: DEPTH-entry circular buffer with valid/ready on both sides.
// in_ready is derived from local occupancy only, so there is no combinational path
// from out_ready to in_ready. A full stage therefore never passes an entry through.
module pipe_stage_elastic #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop, do_flush;

    // Handshake decode and head presentation.
    always_comb begin
        do_flush  = en & flush;
        in_ready  = en & ~flush & (count_q < FULL_CNT);
        out_valid = en & (count_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready & ~flush;
        out_data  = mem_q[rd_ptr_q];
        count     = count_q;
    end

    // Next-state for pointers and occupancy; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Explicit wrap so non-power-of-two depths work.
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register; reset empties the stage immediately.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload array is not reset; stale contents are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic with DEPTH=2, 3 and 4 instances and a
// per-instance queue of expected outputs.
module tb_pipe_stage_elastic;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: DEPTH=2
    logic en0 = 1'b1, fl0 = 1'b0, iv0 = 1'b0, ir0, ov0, or0 = 1'b0;
    logic [63:0] id0 = '0, od0;
    logic [1:0]  cnt0;
    // Instance 1: DEPTH=3
    logic en1 = 1'b1, fl1 = 1'b0, iv1 = 1'b0, ir1, ov1, or1 = 1'b0;
    logic [63:0] id1 = '0, od1;
    logic [1:0]  cnt1;
    // Instance 2: DEPTH=4
    logic en2 = 1'b1, fl2 = 1'b0, iv2 = 1'b0, ir2, ov2, or2 = 1'b0;
    logic [63:0] id2 = '0, od2;
    logic [2:0]  cnt2;

    pipe_stage_elastic #(.DATA_W(64), .DEPTH(2)) u_d2 (
        .clk(clk), .arst_n(arst_n), .en(en0), .flush(fl0),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .count(cnt0)
    );
    pipe_stage_elastic #(.DATA_W(64), .DEPTH(3)) u_d3 (
        .clk(clk), .arst_n(arst_n), .en(en1), .flush(fl1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .count(cnt1)
    );
    pipe_stage_elastic #(.DATA_W(64), .DEPTH(4)) u_d4 (
        .clk(clk), .arst_n(arst_n), .en(en2), .flush(fl2),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .count(cnt2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] q0[$], q1[$], q2[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every transfer seen on an output is checked against the queue head.
    always @(negedge clk) begin
        if (ov0 && or0 && !fl0) begin
            if (q0.size() == 0) chk("d2_unexpected_out", od0, 64'hdead);
            else                chk("d2_out_data", od0, q0.pop_front());
        end
        if (ov1 && or1 && !fl1) begin
            if (q1.size() == 0) chk("d3_unexpected_out", od1, 64'hdead);
            else                chk("d3_out_data", od1, q1.pop_front());
        end
        if (ov2 && or2 && !fl2) begin
            if (q2.size() == 0) chk("d4_unexpected_out", od2, 64'hdead);
            else                chk("d4_out_data", od2, q2.pop_front());
        end
        chk("d2_count_bound", 64'(cnt0 <= 2'd2), 64'd1);
        chk("d3_count_bound", 64'(cnt1 <= 2'd3), 64'd1);
        chk("d4_count_bound", 64'(cnt2 <= 3'd4), 64'd1);
    end

    initial begin
        int unsigned c;
        logic [63:0] nv;
        logic acc, pl;

        // Reset and idle
        #3;
        chk("rst_count", 64'(cnt0), 64'd0);
        chk("rst_out_valid", 64'(ov0), 64'd0);
        chk("rst_in_ready", 64'(ir0), 64'd1);
        #9 arst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); #2;
            chk("idle_count", 64'(cnt0), 64'd0);
            chk("idle_out_valid", 64'(ov0), 64'd0);
            chk("idle_in_ready", 64'(ir0), 64'd1);
        end

        // Streaming through DEPTH=2
        or0 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            iv0 = 1'b1; id0 = 64'(i); q0.push_back(64'(i));
            #2;
            chk("stream_in_ready", 64'(ir0), 64'd1);
            chk("stream_count", 64'(cnt0), (i == 1) ? 64'd0 : 64'd1);
            chk("stream_out_valid", 64'(ov0), (i == 1) ? 64'd0 : 64'd1);
        end
        tick(); iv0 = 1'b0; #2;
        chk("stream_tail_count", 64'(cnt0), 64'd1);
        tick(); #2;
        chk("stream_drained", 64'(cnt0), 64'd0);
        or0 = 1'b0;

        // Full / back-pressure on DEPTH=3
        tick(); iv1 = 1'b1; id1 = 64'hA; q1.push_back(64'hA);
        tick(); id1 = 64'hB; q1.push_back(64'hB);
        tick(); id1 = 64'hC; q1.push_back(64'hC);
        tick(); id1 = 64'hD; #2;
        chk("full_count", 64'(cnt1), 64'd3);
        chk("full_in_ready", 64'(ir1), 64'd0);
        chk("full_head", od1, 64'hA);
        tick(); or1 = 1'b1; #2;
        chk("full_pop_in_ready", 64'(ir1), 64'd0);
        chk("full_pop_count", 64'(cnt1), 64'd3);
        tick(); or1 = 1'b0; #2;
        chk("after_pop_count", 64'(cnt1), 64'd2);
        chk("after_pop_in_ready", 64'(ir1), 64'd1);
        q1.push_back(64'hD);
        tick(); iv1 = 1'b0; #2;
        chk("refill_count", 64'(cnt1), 64'd3);
        or1 = 1'b1;
        repeat (3) tick();
        or1 = 1'b0; #2;
        chk("full_drained", 64'(cnt1), 64'd0);

        // Random interleave with wrap on DEPTH=3
        c = 0;
        nv = 64'h10;
        for (int cyc = 0; cyc < 200 && (nv <= 64'h19 || c != 0); cyc++) begin
            tick();
            iv1 = (nv <= 64'h19) && ($urandom_range(0, 1) == 1);
            id1 = nv;
            or1 = ($urandom_range(0, 1) == 1);
            #2;
            chk("wrap_count", 64'(cnt1), 64'(c));
            acc = iv1 && (c < 3);
            pl  = or1 && (c > 0);
            if (acc) begin
                q1.push_back(nv);
                nv++;
            end
            c = c + 32'(acc) - 32'(pl);
        end
        tick(); iv1 = 1'b0; or1 = 1'b0; #2;
        chk("wrap_drained", 64'(cnt1), 64'd0);
        chk("wrap_all_sent", nv, 64'h1A);

        // Flush on DEPTH=4
        tick(); iv2 = 1'b1; id2 = 64'h21; q2.push_back(64'h21);
        tick(); id2 = 64'h22; q2.push_back(64'h22);
        tick(); id2 = 64'h23; fl2 = 1'b1; #2;
        chk("flush_in_ready", 64'(ir2), 64'd0);
        chk("flush_out_valid", 64'(ov2), 64'd1);
        chk("flush_pre_count", 64'(cnt2), 64'd2);
        q2.delete();
        tick(); fl2 = 1'b0; iv2 = 1'b0; #2;
        chk("flush_count", 64'(cnt2), 64'd0);
        chk("flush_out_valid_low", 64'(ov2), 64'd0);
        tick(); iv2 = 1'b1; id2 = 64'h24; q2.push_back(64'h24);
        tick(); iv2 = 1'b0; #2;
        chk("post_flush_count", 64'(cnt2), 64'd1);
        chk("post_flush_head", od2, 64'h24);
        or2 = 1'b1;
        tick(); or2 = 1'b0; #2;
        chk("post_flush_drained", 64'(cnt2), 64'd0);

        // Enable low, then asynchronous reset mid-transfer
        tick(); iv2 = 1'b1; id2 = 64'h31; q2.push_back(64'h31);
        tick(); id2 = 64'h32; q2.push_back(64'h32);
        tick(); iv2 = 1'b0; #2;
        chk("en_pre_count", 64'(cnt2), 64'd2);
        repeat (3) begin
            tick(); en2 = 1'b0; iv2 = 1'b1; id2 = 64'h33; or2 = 1'b1; #2;
            chk("en_low_in_ready", 64'(ir2), 64'd0);
            chk("en_low_out_valid", 64'(ov2), 64'd0);
            chk("en_low_count", 64'(cnt2), 64'd2);
        end
        tick(); en2 = 1'b1; iv2 = 1'b0; or2 = 1'b0; #2;
        chk("en_back_count", 64'(cnt2), 64'd2);
        chk("en_back_head", od2, 64'h31);
        tick(); iv2 = 1'b1; id2 = 64'h34; or2 = 1'b1;
        q2.delete();
        #2 arst_n = 1'b0;
        #1;
        chk("arst_count", 64'(cnt2), 64'd0);
        chk("arst_out_valid", 64'(ov2), 64'd0);
        iv2 = 1'b0; or2 = 1'b0;
        #4 arst_n = 1'b1;
        tick(); #2;
        chk("post_rst_count", 64'(cnt2), 64'd0);
        chk("post_rst_out_valid", 64'(ov2), 64'd0);
        tick(); iv2 = 1'b1; id2 = 64'h35; q2.push_back(64'h35);
        tick(); iv2 = 1'b0; or2 = 1'b1; #2;
        chk("post_rst_valid", 64'(ov2), 64'd1);
        chk("post_rst_head", od2, 64'h35);
        tick(); or2 = 1'b0; #2;
        chk("post_rst_drained", 64'(cnt2), 64'd0);

        // All expected outputs must have been consumed
        chk("d2_queue_empty", 64'(q0.size()), 64'd0);
        chk("d3_queue_empty", 64'(q1.size()), 64'd0);
        chk("d4_queue_empty", 64'(q2.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
